// File: rtl/mux_nw_pkg.sv
// mux_nw_pkg: shared constants and helpers for the N-channel registered mux.
// Holds mode encodings, default sizing and the channel bounds check.
package mux_nw_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   localparam int DEF_N = 4;
   localparam int DEF_W = 16;

   function automatic logic idx_ok(
      input int unsigned idx,
      input int unsigned n
   );
      return idx < n;
   endfunction

endpackage

// File: rtl/mux_nw_reg_rr_ptr.sv
// rr_ptr: wrapping round-robin counter, 0..max, advances when en is high.
// Ports: clk, rst (sync, active-high), en, max, ptr.
module rr_ptr #(
   parameter int SW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [SW-1:0] max,
   output logic [SW-1:0] ptr
);

   // Explicit compare so non-power-of-2 ranges wrap correctly.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (en)
         ptr <= (ptr == max) ? '0 : ptr + 1'b1;
   end

endmodule

// File: rtl/mux_nw_reg.sv
// mux_nw_reg: N-channel, W-bit registered mux with valid/ready on every port.
// Ports: clk, rst (sync, active-high), d/d_valid/d_ready (N lanes), s, mode,
//        y/y_valid/y_ready, y_ch, sel_err; y_par when MUX_NW_REG_PARITY_EN.
module mux_nw_reg
   import mux_nw_pkg::*;
#(
   parameter  int N  = DEF_N,
   parameter  int W  = DEF_W,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] d,
   input  logic [N-1:0]   d_valid,
   output logic [N-1:0]   d_ready,
   input  logic [SW-1:0]  s,
   input  logic           mode,
   output logic [W-1:0]   y,
   output logic           y_valid,
   input  logic           y_ready,
   output logic [SW-1:0]  y_ch,
`ifdef MUX_NW_REG_PARITY_EN
   output logic           y_par,
`endif
   output logic           sel_err
);

   logic          free;
   logic [SW-1:0] ptr;
   logic [SW-1:0] ch;
   logic          ch_ok;
   logic [W-1:0]  sel_d;
   logic          sel_v;
   logic          load;

   assign free  = !y_valid || y_ready;
   assign ch    = (mode == MODE_SCAN) ? ptr : s;
   assign ch_ok = idx_ok({{(32-SW){1'b0}}, ch}, N);
   assign load  = free && ch_ok && sel_v;

   // Loop compare keeps out-of-range selects from indexing past the vectors;
   // a match only exists for ch < N, so ch_ok is implied per lane.
   always_comb begin
      sel_d   = '0;
      sel_v   = 1'b0;
      d_ready = '0;
      for (int k = 0; k < N; k++) begin
         if (ch == SW'(k)) begin
            sel_d      = d[k*W +: W];
            sel_v      = d_valid[k];
            d_ready[k] = free && !rst;
         end
      end
   end

   rr_ptr #(
      .SW (SW)
   ) u_ptr (
      .clk (clk),
      .rst (rst),
      .en  ((mode == MODE_SCAN) && free),
      .max (SW'(N-1)),
      .ptr (ptr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         y       <= '0;
         y_valid <= 1'b0;
         y_ch    <= '0;
         sel_err <= 1'b0;
      end else begin
         sel_err <= (mode == MODE_DIRECT) && !ch_ok && free;
         if (load) begin
            y       <= sel_d;
            y_ch    <= ch;
            y_valid <= 1'b1;
         end else if (free) begin
            y_valid <= 1'b0;
         end
      end
   end

`ifdef MUX_NW_REG_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst)
         y_par <= 1'b0;
      else if (load)
         y_par <= ^sel_d;
   end
`endif

endmodule

// File: tb/tb_mux_nw_reg.sv
// tb_mux_nw_reg: directed checks of mux_nw_reg at N=4/W=8 and N=3/W=8.
// Covers reset, direct, stall, scan skip/wrap, bad select and parity.
module tb_mux_nw_reg;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // N=4 instance
   logic [31:0] a_d;
   logic [3:0]  a_dv, a_dr;
   logic [1:0]  a_s, a_ych;
   logic        a_mode, a_yv, a_yr, a_se;
   logic [7:0]  a_y;
`ifdef MUX_NW_REG_PARITY_EN
   logic        a_par;
`endif

   // N=3 instance
   logic [23:0] b_d;
   logic [2:0]  b_dv, b_dr;
   logic [1:0]  b_s, b_ych;
   logic        b_mode, b_yv, b_yr, b_se;
   logic [7:0]  b_y;
`ifdef MUX_NW_REG_PARITY_EN
   logic        b_par;
`endif

   mux_nw_reg #(.N(4), .W(8)) dut_a (
      .clk     (clk),
      .rst     (rst),
      .d       (a_d),
      .d_valid (a_dv),
      .d_ready (a_dr),
      .s       (a_s),
      .mode    (a_mode),
      .y       (a_y),
      .y_valid (a_yv),
      .y_ready (a_yr),
      .y_ch    (a_ych),
`ifdef MUX_NW_REG_PARITY_EN
      .y_par   (a_par),
`endif
      .sel_err (a_se)
   );

   mux_nw_reg #(.N(3), .W(8)) dut_b (
      .clk     (clk),
      .rst     (rst),
      .d       (b_d),
      .d_valid (b_dv),
      .d_ready (b_dr),
      .s       (b_s),
      .mode    (b_mode),
      .y       (b_y),
      .y_valid (b_yv),
      .y_ready (b_yr),
      .y_ch    (b_ych),
`ifdef MUX_NW_REG_PARITY_EN
      .y_par   (b_par),
`endif
      .sel_err (b_se)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [7:0] ey,
                        input logic ev, input logic [1:0] ec);
      chk({tag, ".y"}, 32'(a_y), 32'(ey));
      chk({tag, ".yv"}, 32'(a_yv), 32'(ev));
      chk({tag, ".ych"}, 32'(a_ych), 32'(ec));
   endtask

   logic [7:0] sv_y [8];
   logic       sv_v [8];
   logic [1:0] sv_c [8];

   initial begin
      rst = 1'b1;
      a_d = '0; a_dv = '0; a_s = '0; a_mode = 1'b0; a_yr = 1'b0;
      b_d = '0; b_dv = '0; b_s = '0; b_mode = 1'b0; b_yr = 1'b1;
      #1;
      chk("rst_dready_a", 32'(a_dr), 32'h0);
      tick();
      chk_a("rst0", 8'h00, 1'b0, 2'd0);
      chk("rst0.se", 32'(a_se), 32'h0);
      chk("rst0_b.yv", 32'(b_yv), 32'h0);

      // advance ptr to 1 with an idle scan cycle
      rst = 1'b0; a_mode = 1'b1; a_yr = 1'b1;
      tick();
      chk("idle_scan.yv", 32'(a_yv), 32'h0);

      // direct load of A5 then stall, then reset mid-transfer
      a_mode = 1'b0; a_s = 2'd1; a_yr = 1'b0;
      a_d = 32'h0000_A500; a_dv = 4'b0010;
      #1;
      chk("mid.dr0", 32'(a_dr), 32'h2);
      tick();
      chk_a("mid.load", 8'hA5, 1'b1, 2'd1);
      chk("mid.dr_stall", 32'(a_dr), 32'h0);
      tick();
      chk_a("mid.hold", 8'hA5, 1'b1, 2'd1);
      rst = 1'b1;
      #1;
      chk("mid.dr_rst", 32'(a_dr), 32'h0);
      tick();
      chk_a("mid.rst", 8'h00, 1'b0, 2'd0);
      chk("mid.dr_after", 32'(a_dr), 32'h0);
      rst = 1'b0;

      // scan after reset must start at channel 0
      a_mode = 1'b1; a_yr = 1'b1;
      a_d = 32'h4433_2211; a_dv = 4'b1111;
      #1;
      chk("scan0.dr", 32'(a_dr), 32'h1);
      tick();
      chk_a("scan0", 8'h11, 1'b1, 2'd0);
      chk("scan1.dr", 32'(a_dr), 32'h2);
      tick();
      chk_a("scan1", 8'h22, 1'b1, 2'd1);

      // direct back-to-back on channel 2 (ptr now 2, held)
      a_mode = 1'b0; a_s = 2'd2; a_dv = 4'b0100;
      a_d = 32'h0011_0000;
      #1;
      chk("b2b.dr0", 32'(a_dr), 32'h4);
      tick();
      chk_a("b2b0", 8'h11, 1'b1, 2'd2);
      a_d = 32'h0022_0000;
      #1;
      chk("b2b.dr1", 32'(a_dr), 32'h4);
      tick();
      chk_a("b2b1", 8'h22, 1'b1, 2'd2);

      // drain: y and y_ch hold, y_valid drops
      a_dv = 4'b0000;
      tick();
      chk_a("drain", 8'h22, 1'b0, 2'd2);

      // stall on channel 1, then load in the handoff cycle
      a_s = 2'd1; a_d = 32'h0000_3C00; a_dv = 4'b0010;
      tick();
      chk_a("stall.load", 8'h3C, 1'b1, 2'd1);
      a_yr = 1'b0; a_d = 32'h0000_5A00;
      #1;
      chk("stall.dr", 32'(a_dr), 32'h0);
      tick();
      chk_a("stall.h1", 8'h3C, 1'b1, 2'd1);
      tick();
      chk_a("stall.h2", 8'h3C, 1'b1, 2'd1);
      a_yr = 1'b1;
      #1;
      chk("stall.dr_free", 32'(a_dr), 32'h2);
      tick();
      chk_a("stall.handoff", 8'h5A, 1'b1, 2'd1);
      a_dv = 4'b0000;
      tick();
      chk("stall.drain", 32'(a_yv), 32'h0);

      // ptr is 2; two idle scan cycles bring it to 0 via the 3->0 wrap
      a_mode = 1'b1;
      tick();
      tick();
      chk("wrap_pre.yv", 32'(a_yv), 32'h0);

      // scan skip/wrap with channels 0 and 3 valid
      a_d = 32'h3A00_000A; a_dv = 4'b1001;
      sv_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      sv_y = '{8'h0A, 8'h0A, 8'h0A, 8'h3A, 8'h0A, 8'h0A, 8'h0A, 8'h3A};
      sv_c = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3};
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_a($sformatf("scan%0d", i), sv_y[i], sv_v[i], sv_c[i]);
      end
      a_dv = 4'b0000;

`ifdef MUX_NW_REG_PARITY_EN
      a_mode = 1'b0; a_s = 2'd0; a_dv = 4'b0001;
      a_d = 32'h0000_0007;
      tick();
      chk("par07", 32'(a_par), 32'h1);
      a_d = 32'h0000_0003;
      tick();
      chk("par03", 32'(a_par), 32'h0);
      a_yr = 1'b0; a_d = 32'h0000_0001;
      tick();
      chk("par_hold", 32'(a_par), 32'h0);
      a_yr = 1'b1; a_dv = 4'b0000;
`endif

      // N=3: bad select pulses sel_err each free cycle
      b_d = 24'h33_22_11; b_dv = 3'b111; b_s = 2'd3; b_mode = 1'b0;
      #1;
      chk("bad.dr", 32'(b_dr), 32'h0);
      tick();
      chk("bad.se1", 32'(b_se), 32'h1);
      chk("bad.yv1", 32'(b_yv), 32'h0);
      tick();
      chk("bad.se2", 32'(b_se), 32'h1);
      b_s = 2'd0;
      tick();
      chk("good.se", 32'(b_se), 32'h0);
      chk("good.y", 32'(b_y), 32'h11);
      chk("good.yv", 32'(b_yv), 32'h1);
      b_yr = 1'b0; b_s = 2'd3;
      tick();
      chk("badstall.se", 32'(b_se), 32'h0);
      chk("badstall.y", 32'(b_y), 32'h11);

      // N=3 scan wraps 2 -> 0
      b_yr = 1'b1; b_mode = 1'b1;
      tick();
      chk("b_scan0.ch", 32'(b_ych), 32'd0);
      tick();
      chk("b_scan1.ch", 32'(b_ych), 32'd1);
      chk("b_scan1.y", 32'(b_y), 32'h22);
      tick();
      chk("b_scan2.ch", 32'(b_ych), 32'd2);
      chk("b_scan2.y", 32'(b_y), 32'h33);
      tick();
      chk("b_scan3.ch", 32'(b_ych), 32'd0);
      chk("b_scan3.se", 32'(b_se), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
